// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver: FSM states,
// counter width helper and parity-mode constants.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in/parallel-out shift register, LSB-first or MSB-first.
// The first bit shifted in ends up in pout[0] (LSB-first) or pout[DATA_W-1].
module serial_shift_reg #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] pout
);

    logic [DATA_W-1:0] r_sreg;
    logic [DATA_W-1:0] w_sreg_next;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sreg_next = {r_sreg[DATA_W-2:0], serial_in};
        end else begin : g_lsb
            assign w_sreg_next = {serial_in, r_sreg[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (en) begin
            r_sreg <= w_sreg_next;
        end
    end

    assign pout = r_sreg;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: captures a DATA_W-bit frame after a start strobe,
// optional parity, and presents the word through a valid/ready output register.
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              start,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              overrun,
    output logic              frame_abort,
    output logic              busy,
    output logic              wake_transmitter
);

    localparam int               CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             PAR_MODE = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DATA_W-1:0] w_sreg;
    logic [DATA_W-1:0] w_word_next;
    logic [DATA_W-1:0] w_commit_word;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_perr, r_ovr, r_abort;
    logic              w_restart, w_last_bit, w_commit, w_shift_en, w_perr_calc;

    assign w_last_bit = (r_state == SHIFT) && (r_cnt == CNT_LAST);
    assign w_restart  = start && (r_state != IDLE);
    assign w_shift_en = (r_state == SHIFT) && !start;

    serial_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk       (clk),
        .rst       (rst),
        .en        (w_shift_en),
        .serial_in (serial_in),
        .pout      (w_sreg)
    );

    // Word including the bit being sampled now, so a no-parity frame commits
    // on its last bit cycle without waiting for the shift register to settle.
    generate
        if (MSB_FIRST) begin : g_word_msb
            assign w_word_next = {w_sreg[DATA_W-2:0], serial_in};
        end else begin : g_word_lsb
            assign w_word_next = {serial_in, w_sreg[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_commit      = 1'b0;
        w_commit_word = w_word_next;
        w_perr_calc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                    w_cnt_next   = '0;
                end
            end
            SHIFT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_last_bit) begin
                    w_cnt_next = '0;
                    if (PARITY_EN) begin
                        w_state_next = PARITY;
                    end else begin
                        w_state_next = IDLE;
                        w_commit     = 1'b1;
                    end
                end
            end
            PARITY: begin
                w_state_next  = IDLE;
                w_commit      = 1'b1;
                w_commit_word = w_sreg;
                w_perr_calc   = ((^w_sreg) ^ serial_in) != PAR_MODE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // A restart discards the partial frame, even on its final cycle.
        if (w_restart) begin
            w_state_next = SHIFT;
            w_cnt_next   = '0;
            w_commit     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_restart;
            if (w_commit) begin
                if (!r_valid || data_ready) begin
                    r_data  <= w_commit_word;
                    r_perr  <= w_perr_calc;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out         = r_data;
    assign data_valid       = r_valid;
    assign parity_err       = r_perr;
    assign overrun          = r_ovr;
    assign frame_abort      = r_abort;
    assign busy             = (r_state != IDLE);
    assign wake_transmitter = w_last_bit;

endmodule
